xillybus_seekable_mem: RTL and testbench



---
 rtl/xillybus_seekable_mem.sv | 92 +++++++++
 tb/tb_xillybus_seekable_mem.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/xillybus_seekable_mem.sv
// Seekable RAM endpoint for one Xillybus device file: independent read/write
// pointers, 1-cycle read latency, and either stop-at-end (EOF/full) or wrap-around.
module xillybus_seekable_mem #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5,
   parameter bit          WRAP   = 1'b0
) (
   input  logic              bus_clk,
   input  logic              bus_rst_n,
   input  logic              user_w_wren,
   input  logic [DATA_W-1:0] user_w_data,
   output logic              user_w_full,
   input  logic              user_w_open,
   input  logic              user_r_rden,
   output logic [DATA_W-1:0] user_r_data,
   output logic              user_r_empty,
   output logic              user_r_eof,
   input  logic              user_r_open,
   input  logic [ADDR_W-1:0] user_addr,
   input  logic              user_addr_update
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] END_CNT = {1'b1, {ADDR_W{1'b0}}};

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
   logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
   logic [ADDR_W:0]   wr_base;
   logic [ADDR_W-1:0] wr_idx;
   logic [DATA_W-1:0] rd_data_q;
   logic              empty_q, full_q;
   logic              wr_en, rd_en;
   logic              unused_open;

   // The open strobes are informational only.
   assign unused_open = user_w_open ^ user_r_open;

   // A seek clears full on the same edge, so a write riding along with it is accepted.
   assign wr_en   = user_w_wren & (user_addr_update | ~full_q);
   assign rd_en   = user_r_rden & ~empty_q & ~user_addr_update;
   assign wr_base = user_addr_update ? {1'b0, user_addr} : wr_cnt_q;
   assign wr_idx  = wr_base[ADDR_W-1:0];

   always_comb begin
      wr_cnt_d = wr_base;
      if (wr_en) begin
         wr_cnt_d = wr_base + 1'b1;
      end
      rd_cnt_d = user_addr_update ? {1'b0, user_addr} : rd_cnt_q;
      if (rd_en) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
      end
      if (WRAP) begin
         wr_cnt_d[ADDR_W] = 1'b0;
         rd_cnt_d[ADDR_W] = 1'b0;
      end
   end

   // RAM array carries no reset.
   always_ff @(posedge bus_clk) begin
      if (wr_en) begin
         mem[wr_idx] <= user_w_data;
      end
   end

   always_ff @(posedge bus_clk) begin
      if (!bus_rst_n) begin
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         rd_data_q <= '0;
         empty_q   <= 1'b0;
         full_q    <= 1'b0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         // Nonblocking read of mem gives read-first behaviour on a same-index write.
         if (rd_en) begin
            rd_data_q <= mem[rd_cnt_q[ADDR_W-1:0]];
         end
         empty_q <= !WRAP && (rd_cnt_d == END_CNT);
         full_q  <= !WRAP && (wr_cnt_d == END_CNT);
      end
   end

   assign user_r_data  = rd_data_q;
   assign user_r_empty = empty_q;
   assign user_r_eof   = empty_q;
   assign user_w_full  = full_q;

endmodule

// File: tb/tb_xillybus_seekable_mem.sv
// Directed bench: a vector table for the default stop-at-end instance and a
// hand-written sequence for a 32-bit, 8-deep wrapping instance.
module tb_xillybus_seekable_mem;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   // Default instance (DATA_W 8, ADDR_W 5, WRAP 0)
   logic        wren0 = 1'b0, rden0 = 1'b0, upd0 = 1'b0;
   logic [7:0]  wdata0 = '0;
   logic [4:0]  addr0 = '0;
   logic [7:0]  rdata0;
   logic        full0, empty0, eof0;

   // Wrapping instance (DATA_W 32, ADDR_W 3, WRAP 1)
   logic        wren1 = 1'b0, rden1 = 1'b0, upd1 = 1'b0;
   logic [31:0] wdata1 = '0;
   logic [2:0]  addr1 = '0;
   logic [31:0] rdata1;
   logic        full1, empty1, eof1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   xillybus_seekable_mem dut0 (
      .bus_clk          (clk),
      .bus_rst_n        (rst_n),
      .user_w_wren      (wren0),
      .user_w_data      (wdata0),
      .user_w_full      (full0),
      .user_w_open      (1'b1),
      .user_r_rden      (rden0),
      .user_r_data      (rdata0),
      .user_r_empty     (empty0),
      .user_r_eof       (eof0),
      .user_r_open      (1'b1),
      .user_addr        (addr0),
      .user_addr_update (upd0)
   );

   xillybus_seekable_mem #(
      .DATA_W (32),
      .ADDR_W (3),
      .WRAP   (1'b1)
   ) dut1 (
      .bus_clk          (clk),
      .bus_rst_n        (rst_n),
      .user_w_wren      (wren1),
      .user_w_data      (wdata1),
      .user_w_full      (full1),
      .user_w_open      (1'b1),
      .user_r_rden      (rden1),
      .user_r_data      (rdata1),
      .user_r_empty     (empty1),
      .user_r_eof       (eof1),
      .user_r_open      (1'b1),
      .user_addr        (addr1),
      .user_addr_update (upd1)
   );

   typedef struct {
      bit         rst;
      bit         rd;
      bit         wr;
      logic [7:0] wd;
      bit         upd;
      logic [4:0] addr;
      logic [7:0] exp_data;
      bit         exp_empty;
      bit         exp_full;
      string      name;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit rst, bit rd, bit wr, logic [7:0] wd, bit upd,
                               logic [4:0] addr, logic [7:0] ed, bit ee, bit ef,
                               string name);
      vec_t v;
      v.rst = rst; v.rd = rd; v.wr = wr; v.wd = wd; v.upd = upd; v.addr = addr;
      v.exp_data = ed; v.exp_empty = ee; v.exp_full = ef; v.name = name;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //   rst rd wr wd     upd addr  data   emp full name
      add(1, 0, 0, 8'h00, 0, 5'd0, 8'h00, 0, 0, "reset_a");
      add(1, 1, 1, 8'h5A, 0, 5'd0, 8'h00, 0, 0, "reset_b");
      for (int i = 0; i < 32; i++)
         add(0, 0, 1, 8'(i), 0, 5'd0, 8'h00, 0, i == 31, $sformatf("wr_%0d", i));
      add(0, 0, 1, 8'hEE, 0, 5'd0, 8'h00, 0, 1, "wr_dropped");
      add(0, 0, 0, 8'h00, 1, 5'd0, 8'h00, 0, 0, "seek0");
      for (int i = 0; i < 32; i++)
         add(0, 1, 0, 8'h00, 0, 5'd0, 8'(i), i == 31, 0, $sformatf("rd_%0d", i));
      add(0, 1, 0, 8'h00, 0, 5'd0, 8'h1F, 1, 0, "rd_at_eof");
      add(0, 0, 1, 8'hAA, 1, 5'd5, 8'h1F, 0, 0, "seek5_wr");
      add(0, 0, 1, 8'hBB, 0, 5'd0, 8'h1F, 0, 0, "wr_after_seek");
      add(0, 1, 0, 8'h00, 0, 5'd0, 8'hAA, 0, 0, "rd_idx5");
      add(0, 1, 0, 8'h00, 0, 5'd0, 8'hBB, 0, 0, "rd_idx6");
      add(0, 0, 1, 8'h55, 1, 5'd2, 8'hBB, 0, 0, "seek2_wr55");
      add(0, 0, 0, 8'h00, 1, 5'd2, 8'hBB, 0, 0, "seek2");
      add(0, 1, 1, 8'h77, 0, 5'd0, 8'h55, 0, 0, "rd_wr_same_idx");
      add(0, 0, 0, 8'h00, 1, 5'd2, 8'h55, 0, 0, "seek2_again");
      add(0, 1, 0, 8'h00, 0, 5'd0, 8'h77, 0, 0, "rd_new_word");
      add(0, 1, 0, 8'h00, 1, 5'd0, 8'h77, 0, 0, "seek_beats_rd");
      add(0, 1, 0, 8'h00, 0, 5'd0, 8'h00, 0, 0, "rd_after_seek0");
      add(0, 0, 1, 8'h99, 1, 5'd31, 8'h00, 0, 1, "seek31_wr_full");
      add(0, 1, 0, 8'h00, 0, 5'd0, 8'h99, 1, 1, "rd_last_word");
      add(0, 0, 0, 8'h00, 1, 5'd3, 8'h99, 0, 0, "seek3");
      add(0, 1, 0, 8'h00, 0, 5'd0, 8'h03, 0, 0, "rd_idx3");
      add(1, 1, 0, 8'h00, 0, 5'd0, 8'h00, 0, 0, "reset_mid_rd");
      add(0, 1, 0, 8'h00, 0, 5'd0, 8'h00, 0, 0, "rd_after_rst_0");
      add(0, 1, 0, 8'h00, 0, 5'd0, 8'h01, 0, 0, "rd_after_rst_1");

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n  = ~vecs[i].rst;
         rden0  = vecs[i].rd;
         wren0  = vecs[i].wr;
         wdata0 = vecs[i].wd;
         upd0   = vecs[i].upd;
         addr0  = vecs[i].addr;
         tick();
         check({vecs[i].name, ".data"},  32'(rdata0), 32'(vecs[i].exp_data));
         check({vecs[i].name, ".empty"}, 32'(empty0), 32'(vecs[i].exp_empty));
         check({vecs[i].name, ".eof"},   32'(eof0),   32'(vecs[i].exp_empty));
         check({vecs[i].name, ".full"},  32'(full0),  32'(vecs[i].exp_full));
      end
      rst_n = 1'b1; rden0 = 1'b0; wren0 = 1'b0; upd0 = 1'b0;

      // Wrapping instance: seek 6, eight writes cross 7 -> 0 without full.
      upd1 = 1'b1; addr1 = 3'd6;
      tick();
      upd1 = 1'b0;
      check("w_seek6.full", 32'(full1), 32'd0);
      for (int i = 0; i < 8; i++) begin
         wren1 = 1'b1; wdata1 = 32'h11 * 32'(i + 1);
         tick();
         check($sformatf("w_wr_%0d.full", i), 32'(full1), 32'd0);
      end
      wren1 = 1'b0;
      upd1 = 1'b1; addr1 = 3'd6;
      tick();
      upd1 = 1'b0;
      // Nine reads from index 6: the ninth returns to index 6 after wrapping.
      for (int i = 0; i < 9; i++) begin
         rden1 = 1'b1;
         tick();
         check($sformatf("w_rd_%0d.data", i), rdata1, 32'h11 * 32'((i % 8) + 1));
         check($sformatf("w_rd_%0d.empty", i), 32'(empty1 | eof1), 32'd0);
      end
      rden1 = 1'b0;
      upd1 = 1'b1; addr1 = 3'd0;
      tick();
      upd1 = 1'b0; rden1 = 1'b1;
      tick();
      rden1 = 1'b0;
      check("w_rd_idx0.data", rdata1, 32'h33);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
